// File: rtl/systolic_mm_engine_pkg.sv
// Shared state encoding and sizing helpers for the output-stationary systolic
// matrix-multiply engine and its processing elements.
package systolic_mm_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_OUT
   } state_t;

   function automatic int productWidth(input int dataWidth);
      return 2 * dataWidth;
   endfunction

   function automatic int drainCycles(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Control, operand-stream and result-stream bundle of the systolic engine.
// Signal prefixes are from the engine's side: i_ flows in, o_ flows out.
interface systolic_mm_engine_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int K_WIDTH    = 8
);
   logic                        i_start;
   logic [K_WIDTH-1:0]          i_k_len;
   logic                        o_busy;
   logic                        i_in_valid;
   logic                        o_in_ready;
   logic [ROWS*DATA_WIDTH-1:0]  i_a_col;
   logic [COLS*DATA_WIDTH-1:0]  i_b_row;
   logic                        o_out_valid;
   logic                        i_out_ready;
   logic [$clog2(ROWS)-1:0]     o_out_row;
   logic [COLS*ACC_WIDTH-1:0]   o_out_data;
   logic                        o_out_last;
   logic                        o_done;

   modport master (
      output i_start, i_k_len, i_in_valid, i_a_col, i_b_row, i_out_ready,
      input  o_busy, o_in_ready, o_out_valid, o_out_row, o_out_data, o_out_last, o_done
   );

   modport slave (
      input  i_start, i_k_len, i_in_valid, i_a_col, i_b_row, i_out_ready,
      output o_busy, o_in_ready, o_out_valid, o_out_row, o_out_data, o_out_last, o_done
   );
endinterface

// File: rtl/systolic_mac_pe.sv
// One output-stationary PE: forwards its operands right/down one cycle later
// and accumulates their product until frozen or cleared.
module systolic_mac_pe
   import systolic_mm_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter bit SIGNED     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_freeze,
   input  logic [DATA_WIDTH-1:0] i_left,
   input  logic [DATA_WIDTH-1:0] i_top,
   output logic [DATA_WIDTH-1:0] o_right,
   output logic [DATA_WIDTH-1:0] o_down,
   output logic [ACC_WIDTH-1:0]  o_acc
);
   localparam int PW = productWidth(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] r_right;
   logic [DATA_WIDTH-1:0] r_down;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic [PW-1:0]         w_prod;
   logic [ACC_WIDTH-1:0]  w_prodExt;

   // Operands are widened to the full product width before multiplying.
   always_comb begin
      if (SIGNED) begin
         w_prod    = PW'($signed(i_left)) * PW'($signed(i_top));
         w_prodExt = ACC_WIDTH'($signed(w_prod));
      end else begin
         w_prod    = PW'(i_left) * PW'(i_top);
         w_prodExt = ACC_WIDTH'(w_prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_right <= '0;
         r_down  <= '0;
         r_acc   <= '0;
      end else if (i_clear) begin
         r_right <= '0;
         r_down  <= '0;
         r_acc   <= '0;
      end else if (!i_freeze) begin
         r_right <= i_left;
         r_down  <= i_top;
         r_acc   <= r_acc + w_prodExt;
      end
   end

   assign o_right = r_right;
   assign o_down  = r_down;
   assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_mm_engine.sv
// ROWSxCOLS output-stationary systolic engine: job FSM, operand skew lines,
// PE grid and result-row streaming.
module systolic_mm_engine
   import systolic_mm_engine_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24,
   parameter int ROWS       = 16,
   parameter int COLS       = 16,
   parameter int K_WIDTH    = 8,
   parameter bit SIGNED     = 1'b1
) (
   input logic                 clk,
   input logic                 rst_n,
   systolic_mm_engine_if.slave bus
);
   localparam int DRAIN_CYCLES = drainCycles(ROWS, COLS);
   localparam int DCW          = $clog2(DRAIN_CYCLES + 1);
   localparam int RW           = $clog2(ROWS);

   state_t             r_state;
   logic [K_WIDTH-1:0] r_kCnt;
   logic [DCW-1:0]     r_drainCnt;
   logic [RW-1:0]      r_outRow;
   logic               r_busy;
   logic               r_inReady;
   logic               r_outValid;
   logic               r_outLast;
   logic               r_done;

   logic                       w_beat;
   logic                       w_clear;
   logic                       w_freeze;
   logic [DATA_WIDTH-1:0]      w_aInj [ROWS];
   logic [DATA_WIDTH-1:0]      w_bInj [COLS];
   logic [DATA_WIDTH-1:0]      w_hor  [ROWS][COLS];
   logic [DATA_WIDTH-1:0]      w_ver  [ROWS][COLS];
   logic [COLS*ACC_WIDTH-1:0]  w_accRow [ROWS];

   assign w_beat   = bus.i_in_valid & r_inReady;
   assign w_clear  = (r_state == ST_CLEAR);
   assign w_freeze = !((r_state == ST_FEED) || (r_state == ST_DRAIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_kCnt     <= '0;
         r_drainCnt <= '0;
         r_outRow   <= '0;
         r_busy     <= 1'b0;
         r_inReady  <= 1'b0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (bus.i_start) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
                  r_kCnt  <= bus.i_k_len;
               end
            end
            ST_CLEAR: begin
               r_drainCnt <= '0;
               if (r_kCnt != '0) begin
                  r_state   <= ST_FEED;
                  r_inReady <= 1'b1;
               end else begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_FEED: begin
               if (w_beat) begin
                  r_kCnt <= r_kCnt - K_WIDTH'(1);
                  if (r_kCnt == K_WIDTH'(1)) begin
                     r_state   <= ST_DRAIN;
                     r_inReady <= 1'b0;
                  end
               end
            end
            // Long enough for the last beat to reach the far corner PE.
            ST_DRAIN: begin
               if (r_drainCnt == DCW'(DRAIN_CYCLES - 1)) begin
                  r_state    <= ST_OUT;
                  r_outValid <= 1'b1;
                  r_outRow   <= '0;
                  r_outLast  <= (ROWS == 1);
               end else begin
                  r_drainCnt <= r_drainCnt + DCW'(1);
               end
            end
            ST_OUT: begin
               if (bus.i_out_ready) begin
                  if (r_outRow == RW'(ROWS - 1)) begin
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                     r_outValid <= 1'b0;
                     r_outLast  <= 1'b0;
                     r_outRow   <= '0;
                     r_done     <= 1'b1;
                  end else begin
                     r_outRow  <= r_outRow + RW'(1);
                     r_outLast <= (r_outRow == RW'(ROWS - 2));
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Row i of A is delayed i cycles so it meets column j of B in PE(i,j).
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_aSkew
      assign w_aInj[gi] = w_beat ? bus.i_a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gi == 0) begin : g_direct
         assign w_hor[gi][0] = w_aInj[gi];
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] r_line [gi];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < gi; d++) r_line[d] <= '0;
            end else if (w_clear) begin
               for (int d = 0; d < gi; d++) r_line[d] <= '0;
            end else if (!w_freeze) begin
               r_line[0] <= w_aInj[gi];
               for (int d = 1; d < gi; d++) r_line[d] <= r_line[d-1];
            end
         end
         assign w_hor[gi][0] = r_line[gi-1];
      end
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : g_bSkew
      assign w_bInj[gj] = w_beat ? bus.i_b_row[gj*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gj == 0) begin : g_direct
         assign w_ver[0][gj] = w_bInj[gj];
      end else begin : g_delay
         logic [DATA_WIDTH-1:0] r_line [gj];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < gj; d++) r_line[d] <= '0;
            end else if (w_clear) begin
               for (int d = 0; d < gj; d++) r_line[d] <= '0;
            end else if (!w_freeze) begin
               r_line[0] <= w_bInj[gj];
               for (int d = 1; d < gj; d++) r_line[d] <= r_line[d-1];
            end
         end
         assign w_ver[0][gj] = r_line[gj-1];
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         logic [DATA_WIDTH-1:0] w_right;
         logic [DATA_WIDTH-1:0] w_down;
         logic [ACC_WIDTH-1:0]  w_acc;

         systolic_mac_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SIGNED     (SIGNED)
         ) u_pe (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clear  (w_clear),
            .i_freeze (w_freeze),
            .i_left   (w_hor[gi][gj]),
            .i_top    (w_ver[gi][gj]),
            .o_right  (w_right),
            .o_down   (w_down),
            .o_acc    (w_acc)
         );

         assign w_accRow[gi][gj*ACC_WIDTH +: ACC_WIDTH] = w_acc;

         if (gj < COLS - 1) begin : g_passRight
            assign w_hor[gi][gj+1] = w_right;
         end else begin : g_edgeRight
            logic [DATA_WIDTH-1:0] w_unusedRight;
            assign w_unusedRight = w_right;
         end

         if (gi < ROWS - 1) begin : g_passDown
            assign w_ver[gi+1][gj] = w_down;
         end else begin : g_edgeDown
            logic [DATA_WIDTH-1:0] w_unusedDown;
            assign w_unusedDown = w_down;
         end
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_in_ready  = r_inReady;
   assign bus.o_out_valid = r_outValid;
   assign bus.o_out_row   = r_outRow;
   assign bus.o_out_last  = r_outLast;
   assign bus.o_done      = r_done;
   assign bus.o_out_data  = w_accRow[r_outRow];

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Drives a signed/24-bit and an unsigned/16-bit 4x4 engine in lockstep and
// checks every result row against a plain-arithmetic matrix product.
module tb_systolic_mm_engine;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int curK  = 0;
   logic [7:0] matA [N][16];
   logic [7:0] matB [16][N];

   systolic_mm_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .ROWS(N), .COLS(N), .K_WIDTH(8)) busS ();
   systolic_mm_engine_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ROWS(N), .COLS(N), .K_WIDTH(8)) busU ();

   assign busU.i_start     = busS.i_start;
   assign busU.i_k_len     = busS.i_k_len;
   assign busU.i_in_valid  = busS.i_in_valid;
   assign busU.i_a_col     = busS.i_a_col;
   assign busU.i_b_row     = busS.i_b_row;
   assign busU.i_out_ready = busS.i_out_ready;

   systolic_mm_engine #(.DATA_WIDTH(8), .ACC_WIDTH(24), .ROWS(N), .COLS(N), .K_WIDTH(8), .SIGNED(1'b1))
      dutS (.clk(clk), .rst_n(rst_n), .bus(busS));
   systolic_mm_engine #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ROWS(N), .COLS(N), .K_WIDTH(8), .SIGNED(1'b0))
      dutU (.clk(clk), .rst_n(rst_n), .bus(busU));

   function automatic logic [95:0] refRowS(input int row);
      logic [95:0] v;
      longint s;
      v = '0;
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int k = 0; k < curK; k++)
            s += longint'($signed(matA[row][k])) * longint'($signed(matB[k][j]));
         v[j*24 +: 24] = s[23:0];
      end
      return v;
   endfunction

   function automatic logic [95:0] refRowU(input int row);
      logic [95:0] v;
      longint s;
      v = '0;
      for (int j = 0; j < N; j++) begin
         s = 0;
         for (int k = 0; k < curK; k++)
            s += longint'(matA[row][k]) * longint'(matB[k][j]);
         v[j*16 +: 16] = s[15:0];
      end
      return v;
   endfunction

   task automatic checkEq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic setBeat(input int idx);
      for (int i = 0; i < N; i++) begin
         busS.i_a_col[i*8 +: 8] = matA[i][idx];
         busS.i_b_row[i*8 +: 8] = matB[idx][i];
      end
   endtask

   task automatic fillConst(input logic [7:0] a, input logic [7:0] b);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 16; k++) begin
            matA[i][k] = a;
            matB[k][i] = b;
         end
   endtask

   task automatic fillRandom();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 16; k++) begin
            matA[i][k] = 8'($urandom);
            matB[k][i] = 8'($urandom);
         end
   endtask

   task automatic checkOutput(input int row);
      checkEq("outRowS", 96'(busS.o_out_row), 96'(row));
      checkEq("outRowU", 96'(busU.o_out_row), 96'(row));
      checkEq("outLast", 96'(busS.o_out_last), 96'(row == N - 1));
      checkEq("dataS", 96'(busS.o_out_data), refRowS(row));
      checkEq("dataU", 96'(busU.o_out_data), refRowU(row));
   endtask

   // Called and returns at a falling edge, so jobs can run back to back.
   task automatic applyStimulus(input int kLen, input bit bubbles, input bit backPress, input bit pokeStart);
      int beats;
      int cyc;
      int rowsSeen;
      int firstValid;
      bit valid;
      curK = kLen;
      busS.i_start    = 1'b1;
      busS.i_k_len    = 8'(kLen);
      busS.i_in_valid = 1'b1;
      setBeat(0);
      @(negedge clk);
      busS.i_start = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < kLen && cyc < 200) begin
         valid = !(bubbles && (cyc % 2 == 1));
         busS.i_in_valid = valid;
         setBeat(beats);
         if (cyc == 0) begin
            checkEq("busyClear", 96'(busS.o_busy), 96'(1));
            checkEq("inReadyClear", 96'(busS.o_in_ready), 96'(0));
         end
         if (pokeStart && cyc == 1) begin
            busS.i_start = 1'b1;
            busS.i_k_len = 8'd7;
         end else begin
            busS.i_start = 1'b0;
         end
         if (valid && busS.o_in_ready) beats++;
         cyc++;
         @(negedge clk);
      end
      busS.i_in_valid = 1'b0;
      busS.i_start    = 1'b0;
      checkEq("feedBeats", 96'(beats), 96'(kLen));
      rowsSeen   = 0;
      firstValid = -1;
      cyc        = 0;
      while (rowsSeen < N && cyc < 300) begin
         busS.i_out_ready = backPress ? (cyc % 2 == 0) : 1'b1;
         if (busS.o_out_valid) begin
            if (firstValid < 0) firstValid = cyc;
            checkOutput(rowsSeen);
            if (busS.i_out_ready) rowsSeen++;
         end
         cyc++;
         @(negedge clk);
      end
      busS.i_out_ready = 1'b0;
      checkEq("rowsSeen", 96'(rowsSeen), 96'(N));
      checkEq("drainLatency", 96'(firstValid), 96'((kLen == 0) ? 2 * N : 2 * N - 1));
      checkEq("donePulse", 96'({busS.o_done, busU.o_done}), 96'(2'b11));
      checkEq("busyIdle", 96'(busS.o_busy), 96'(0));
      checkEq("validIdle", 96'(busS.o_out_valid), 96'(0));
      @(negedge clk);
      checkEq("doneLow", 96'(busS.o_done), 96'(0));
   endtask

   initial begin
      rst_n            = 1'b0;
      busS.i_start     = 1'b0;
      busS.i_k_len     = '0;
      busS.i_in_valid  = 1'b0;
      busS.i_a_col     = '0;
      busS.i_b_row     = '0;
      busS.i_out_ready = 1'b0;
      fillConst(8'd0, 8'd0);
      #1;
      checkEq("rstBusy", 96'(busS.o_busy), 96'(0));
      checkEq("rstInReady", 96'(busS.o_in_ready), 96'(0));
      checkEq("rstOutValid", 96'(busS.o_out_valid), 96'(0));
      checkEq("rstOutLast", 96'(busS.o_out_last), 96'(0));
      checkEq("rstDone", 96'(busS.o_done), 96'(0));
      checkEq("rstOutRow", 96'(busS.o_out_row), 96'(0));
      checkEq("rstDataS", 96'(busS.o_out_data), 96'(0));
      checkEq("rstDataU", 96'(busU.o_out_data), 96'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < N; i++)
         for (int k = 0; k < 16; k++) begin
            matA[i][k] = (i == k) ? 8'd1 : 8'd0;
            matB[k][i] = 8'(k * 4 + i);
         end
      applyStimulus(4, 1'b0, 1'b0, 1'b0);

      fillConst(8'hFD, 8'd5);
      applyStimulus(2, 1'b0, 1'b0, 1'b0);

      fillRandom();
      applyStimulus(3, 1'b1, 1'b1, 1'b0);
      applyStimulus(3, 1'b0, 1'b0, 1'b0);

      fillConst(8'hFF, 8'hFF);
      applyStimulus(2, 1'b0, 1'b0, 1'b0);

      applyStimulus(0, 1'b0, 1'b0, 1'b0);

      fillRandom();
      applyStimulus(3, 1'b0, 1'b0, 1'b1);

      fillRandom();
      busS.i_start    = 1'b1;
      busS.i_k_len    = 8'd4;
      busS.i_in_valid = 1'b1;
      setBeat(0);
      @(negedge clk);
      busS.i_start = 1'b0;
      @(negedge clk);
      setBeat(1);
      @(negedge clk);
      checkEq("abortInFeed", 96'({busS.o_busy, busS.o_in_ready}), 96'(2'b11));
      rst_n = 1'b0;
      #1;
      checkEq("abortBusy", 96'(busS.o_busy), 96'(0));
      checkEq("abortInReady", 96'(busS.o_in_ready), 96'(0));
      checkEq("abortDone", 96'(busS.o_done), 96'(0));
      checkEq("abortDataS", 96'(busS.o_out_data), 96'(0));
      @(negedge clk);
      busS.i_in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      fillConst(8'd2, 8'd3);
      applyStimulus(1, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         fillRandom();
         applyStimulus(int'($urandom_range(1, 8)), t[0], t[1], 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
